// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch, load and store requests onto one RAM controller
//
// Purpose: picks one of the fetch/load/store requesters in IDLE, latches its fields,
// drives the matching RAM port in ISSUE until the controller answers, then spends one
// GAP cycle before arbitrating again. One transaction is outstanding at most.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable / freeze)
//   clear_in            pipeline flush; blocks new fetch/load, cancels in-flight fetch/load
//   io_buffer_full_in   blocks stores into the I/O region
//   if_*  fetch requester   ld_* load requester   st_* store requester
//   mem_inst_*          instruction port to the RAM controller
//   mem_data_*          data port to the RAM controller (rw 1 = write)
//   busy_out            high whenever a transaction is in progress (state != IDLE)
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_SEL       = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        io_buffer_full_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ack_out,
  output logic [31:0] if_inst_out,
  input  logic        ld_req_in,
  input  logic [31:0] ld_addr_in,
  input  logic [2:0]  ld_width_in,
  input  logic        ld_sgn_in,
  output logic        ld_ack_out,
  output logic [31:0] ld_data_out,
  input  logic        st_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [2:0]  st_width_in,
  input  logic [31:0] st_data_in,
  output logic        st_ack_out,
  output logic        mem_inst_en_out,
  output logic [31:0] mem_inst_addr_out,
  input  logic        mem_inst_rdy_in,
  input  logic [31:0] mem_inst_in,
  output logic        mem_data_en_out,
  output logic        mem_data_rw_out,
  output logic        mem_data_sgn_out,
  output logic [2:0]  mem_data_width_out,
  output logic [31:0] mem_data_addr_out,
  output logic [31:0] mem_data_out,
  input  logic        mem_data_rdy_in,
  input  logic [31:0] mem_data_in,
  output logic        busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
  typedef enum logic [1:0] {K_NONE, K_IF, K_LD, K_ST} kind_t;

  localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);
  localparam logic [2:0] STARVE_MAX = 3'd7;

  state_t     state, state_nxt;
  kind_t      kind, grant;
  logic [2:0] starve_cnt;
  logic       cancel;
  logic       done;
  logic       st_elig, ld_elig, if_elig, starved;

  // A flush only blocks speculative traffic; stores are architectural and may proceed.
  assign st_elig = st_req_in && !((st_addr_in[17:16] == IO_SEL) && io_buffer_full_in);
  assign ld_elig = ld_req_in && !clear_in;
  assign if_elig = if_req_in && !clear_in;
  assign starved = (starve_cnt >= LIMIT) && if_elig;

  assign busy_out        = (state != S_IDLE);
  assign mem_inst_en_out = (state == S_ISSUE) && (kind == K_IF);
  assign mem_data_en_out = (state == S_ISSUE) && ((kind == K_LD) || (kind == K_ST));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = K_NONE;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (starved)      grant = K_IF;
        else if (st_elig) grant = K_ST;
        else if (ld_elig) grant = K_LD;
        else if (if_elig) grant = K_IF;
        if (grant != K_NONE) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // Only the port that was granted can complete the transaction.
        done = ((kind == K_IF) && mem_inst_rdy_in) ||
               (((kind == K_LD) || (kind == K_ST)) && mem_data_rdy_in);
        if (done) state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      kind               <= K_NONE;
      starve_cnt         <= 3'd0;
      cancel             <= 1'b0;
      if_ack_out         <= 1'b0;
      ld_ack_out         <= 1'b0;
      st_ack_out         <= 1'b0;
      if_inst_out        <= 32'd0;
      ld_data_out        <= 32'd0;
      mem_inst_addr_out  <= 32'd0;
      mem_data_rw_out    <= 1'b0;
      mem_data_sgn_out   <= 1'b0;
      mem_data_width_out <= 3'd0;
      mem_data_addr_out  <= 32'd0;
      mem_data_out       <= 32'd0;
    end else if (rdy_in) begin
      if_ack_out <= 1'b0;
      ld_ack_out <= 1'b0;
      st_ack_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant != K_NONE) begin
            kind <= grant;
            if (grant == K_IF) begin
              starve_cnt <= 3'd0;
            end else if (if_req_in && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 3'd1;
            end
          end
          case (grant)
            K_IF: mem_inst_addr_out <= if_addr_in;
            K_LD: begin
              mem_data_rw_out    <= 1'b0;
              mem_data_sgn_out   <= ld_sgn_in;
              mem_data_width_out <= ld_width_in;
              mem_data_addr_out  <= ld_addr_in;
              mem_data_out       <= 32'd0;
            end
            K_ST: begin
              mem_data_rw_out    <= 1'b1;
              mem_data_sgn_out   <= 1'b0;
              mem_data_width_out <= st_width_in;
              mem_data_addr_out  <= st_addr_in;
              mem_data_out       <= st_data_in;
            end
            default: ;
          endcase
        end
        S_ISSUE: begin
          if (clear_in && (kind != K_ST)) cancel <= 1'b1;
          if (done) begin
            // A flush in the completing cycle counts as well as an earlier one.
            cancel <= 1'b0;
            if (!(cancel || clear_in)) begin
              if (kind == K_IF) begin
                if_inst_out <= mem_inst_in;
                if_ack_out  <= 1'b1;
              end
              if (kind == K_LD) begin
                ld_data_out <= mem_data_in;
                ld_ack_out  <= 1'b1;
              end
            end
            if (kind == K_ST) st_ack_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, io_buffer_full_in;
  logic        if_req_in, if_ack_out;
  logic [31:0] if_addr_in, if_inst_out;
  logic        ld_req_in, ld_sgn_in, ld_ack_out;
  logic [31:0] ld_addr_in, ld_data_out;
  logic [2:0]  ld_width_in;
  logic        st_req_in, st_ack_out;
  logic [31:0] st_addr_in, st_data_in;
  logic [2:0]  st_width_in;
  logic        mem_inst_en_out, mem_inst_rdy_in;
  logic [31:0] mem_inst_addr_out, mem_inst_in;
  logic        mem_data_en_out, mem_data_rw_out, mem_data_sgn_out, mem_data_rdy_in;
  logic [2:0]  mem_data_width_out;
  logic [31:0] mem_data_addr_out, mem_data_out, mem_data_in;
  logic        busy_out;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  ack_q[$];
  logic        overlap = 1'b0;
  logic        auto_resp = 1'b0;
  logic        drop_if = 1'b1, drop_ld = 1'b1, drop_st = 1'b1;
  int          wc = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.STARVE_LIMIT(4), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .io_buffer_full_in(io_buffer_full_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_ack_out(if_ack_out),
    .if_inst_out(if_inst_out),
    .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_width_in(ld_width_in),
    .ld_sgn_in(ld_sgn_in), .ld_ack_out(ld_ack_out), .ld_data_out(ld_data_out),
    .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_width_in(st_width_in),
    .st_data_in(st_data_in), .st_ack_out(st_ack_out),
    .mem_inst_en_out(mem_inst_en_out), .mem_inst_addr_out(mem_inst_addr_out),
    .mem_inst_rdy_in(mem_inst_rdy_in), .mem_inst_in(mem_inst_in),
    .mem_data_en_out(mem_data_en_out), .mem_data_rw_out(mem_data_rw_out),
    .mem_data_sgn_out(mem_data_sgn_out), .mem_data_width_out(mem_data_width_out),
    .mem_data_addr_out(mem_data_addr_out), .mem_data_out(mem_data_out),
    .mem_data_rdy_in(mem_data_rdy_in), .mem_data_in(mem_data_in),
    .busy_out(busy_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // RAM model: answers two cycles after a port enable rises. Fetch returns addr ^ 0x11110000,
  // load returns addr + 0x5000.
  initial forever begin
    @(negedge clk_in);
    if (auto_resp) begin
      mem_inst_rdy_in = 1'b0;
      mem_data_rdy_in = 1'b0;
      if (mem_inst_en_out) begin
        wc++;
        if (wc >= 2) begin
          mem_inst_rdy_in = 1'b1;
          mem_inst_in     = mem_inst_addr_out ^ 32'h1111_0000;
          wc = 0;
        end
      end else if (mem_data_en_out) begin
        wc++;
        if (wc >= 2) begin
          mem_data_rdy_in = 1'b1;
          mem_data_in     = mem_data_addr_out + 32'h5000;
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Ack monitor: records ack order (1 fetch, 2 load, 3 store); requesters drop req after ack.
  initial forever begin
    @(posedge clk_in);
    #1;
    if ((int'(if_ack_out) + int'(ld_ack_out) + int'(st_ack_out)) > 1) overlap = 1'b1;
    if (st_ack_out) begin ack_q.push_back(2'd3); if (drop_st) st_req_in = 1'b0; end
    if (ld_ack_out) begin ack_q.push_back(2'd2); if (drop_ld) ld_req_in = 1'b0; end
    if (if_ack_out) begin ack_q.push_back(2'd1); if (drop_if) if_req_in = 1'b0; end
  end

  task automatic wait_inst_en(input int budget);
    int n = 0;
    while (!mem_inst_en_out && n < budget) begin @(negedge clk_in); n++; end
    check("wait_inst_en", mem_inst_en_out, 1);
  endtask

  task automatic wait_data_en(input logic rw, input int budget);
    int n = 0;
    while (!(mem_data_en_out && mem_data_rw_out == rw) && n < budget) begin
      @(negedge clk_in); n++;
    end
    check("wait_data_en", mem_data_en_out, 1);
  endtask

  task automatic wait_acks(input int cnt, input int budget);
    int n = 0;
    while (ack_q.size() < cnt && n < budget) begin @(negedge clk_in); n++; end
    check("ack_count", ack_q.size(), cnt);
  endtask

  initial begin
    int base;
    logic [1:0] exp_order[10];
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = 32'd0;
    ld_req_in = 1'b0; ld_addr_in = 32'd0; ld_width_in = 3'b100; ld_sgn_in = 1'b0;
    st_req_in = 1'b0; st_addr_in = 32'd0; st_width_in = 3'b100; st_data_in = 32'd0;
    mem_inst_rdy_in = 1'b0; mem_inst_in = 32'd0; mem_data_rdy_in = 1'b0; mem_data_in = 32'd0;

    // Reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_busy", busy_out, 0);
    check("rst_inst_en", mem_inst_en_out, 0);
    check("rst_data_en", mem_data_en_out, 0);
    check("rst_acks", {if_ack_out, ld_ack_out, st_ack_out}, 0);
    check("rst_data_addr", mem_data_addr_out, 0);
    check("rst_ld_data", ld_data_out, 0);
    rst_in = 1'b0;
    auto_resp = 1'b1;

    // Simultaneous requests: store, then load, then fetch
    @(negedge clk_in);
    st_addr_in = 32'h100; st_data_in = 32'hDEADBEEF; st_width_in = 3'b100; st_req_in = 1'b1;
    ld_addr_in = 32'h300; ld_width_in = 3'b001; ld_sgn_in = 1'b1; ld_req_in = 1'b1;
    if_addr_in = 32'h1000; if_req_in = 1'b1;
    wait_data_en(1'b1, 20);
    check("st_addr", mem_data_addr_out, 32'h100);
    check("st_data", mem_data_out, 32'hDEADBEEF);
    check("st_width", mem_data_width_out, 3'b100);
    check("st_sgn", mem_data_sgn_out, 0);
    check("st_busy", busy_out, 1);
    check("st_no_inst_en", mem_inst_en_out, 0);
    wait_data_en(1'b0, 20);
    check("ld_addr", mem_data_addr_out, 32'h300);
    check("ld_width", mem_data_width_out, 3'b001);
    check("ld_sgn", mem_data_sgn_out, 1);
    check("ld_mem_data_zero", mem_data_out, 0);
    wait_acks(3, 60);
    check("order0_st", ack_q[0], 3);
    check("order1_ld", ack_q[1], 2);
    check("order2_if", ack_q[2], 1);
    check("ld_result", ld_data_out, 32'h5300);
    check("if_result", if_inst_out, 32'h1111_1000);

    // Starvation: continuous stores keep winning until the 4th data grant, then fetch
    repeat (3) @(negedge clk_in);
    ack_q.delete();
    drop_if = 1'b0; drop_ld = 1'b0; drop_st = 1'b0;
    st_addr_in = 32'h104; st_req_in = 1'b1;
    ld_addr_in = 32'h108; ld_req_in = 1'b1;
    if_addr_in = 32'h2000; if_req_in = 1'b1;
    exp_order = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    wait_acks(10, 200);
    st_req_in = 1'b0; ld_req_in = 1'b0; if_req_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < ack_q.size()) check($sformatf("starve_order%0d", i), ack_q[i], exp_order[i]);
    end
    drop_if = 1'b1; drop_ld = 1'b1; drop_st = 1'b1;

    // I/O store blocked by a full buffer; load goes first
    repeat (4) @(negedge clk_in);
    ack_q.delete();
    io_buffer_full_in = 1'b1;
    st_addr_in = 32'h30000; st_data_in = 32'h55; st_req_in = 1'b1;
    ld_addr_in = 32'h400; ld_width_in = 3'b100; ld_sgn_in = 1'b0; ld_req_in = 1'b1;
    wait_acks(1, 40);
    check("io_first_is_ld", ack_q[0], 2);
    check("io_ld_result", ld_data_out, 32'h5400);
    repeat (5) @(negedge clk_in);
    check("io_blocked_busy", busy_out, 0);
    check("io_blocked_en", mem_data_en_out, 0);
    io_buffer_full_in = 1'b0;
    @(negedge clk_in);
    check("io_st_granted", mem_data_en_out, 1);
    check("io_st_rw", mem_data_rw_out, 1);
    check("io_st_addr", mem_data_addr_out, 32'h30000);
    wait_acks(2, 40);
    check("io_second_is_st", ack_q[1], 3);

    // Flush during an in-flight load: completes downstream, no ack, data unchanged
    repeat (3) @(negedge clk_in);
    auto_resp = 1'b0;
    mem_data_rdy_in = 1'b0; mem_inst_rdy_in = 1'b0;
    base = ack_q.size();
    ld_addr_in = 32'h200; ld_width_in = 3'b010; ld_req_in = 1'b1;
    wait_data_en(1'b0, 20);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    check("cancel_en_held1", mem_data_en_out, 1);
    @(negedge clk_in);
    check("cancel_en_held2", mem_data_en_out, 1);
    mem_data_rdy_in = 1'b1; mem_data_in = 32'h1234_5678; ld_req_in = 1'b0;
    @(negedge clk_in);
    mem_data_rdy_in = 1'b0;
    check("cancel_en_drop", mem_data_en_out, 0);
    check("cancel_gap_busy", busy_out, 1);
    check("cancel_no_ack", ld_ack_out, 0);
    check("cancel_data_kept", ld_data_out, 32'h5400);
    @(negedge clk_in);
    check("cancel_idle", busy_out, 0);
    check("cancel_ack_total", ack_q.size(), base);

    // Freeze with rdy_in low during a fetch; stray rdy pulses ignored
    repeat (2) @(negedge clk_in);
    if_addr_in = 32'h40; if_req_in = 1'b1;
    wait_inst_en(20);
    mem_data_rdy_in = 1'b1;
    @(negedge clk_in);
    mem_data_rdy_in = 1'b0;
    check("wrong_port_en", mem_inst_en_out, 1);
    check("wrong_port_ack", if_ack_out, 0);
    rdy_in = 1'b0;
    mem_inst_rdy_in = 1'b1; mem_inst_in = 32'h0BAD_0BAD;
    @(negedge clk_in);
    mem_inst_rdy_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("frz_en", mem_inst_en_out, 1);
    check("frz_addr", mem_inst_addr_out, 32'h40);
    check("frz_busy", busy_out, 1);
    check("frz_no_ack", if_ack_out, 0);
    check("frz_inst_kept", if_inst_out, 32'h1111_2000);
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("frz_resume_en", mem_inst_en_out, 1);
    mem_inst_rdy_in = 1'b1; mem_inst_in = 32'hCAFE_F00D;
    @(negedge clk_in);
    mem_inst_rdy_in = 1'b0;
    check("frz_ack", if_ack_out, 1);
    check("frz_result", if_inst_out, 32'hCAFE_F00D);
    check("frz_en_drop", mem_inst_en_out, 0);

    // Reset mid-fetch
    repeat (3) @(negedge clk_in);
    base = ack_q.size();
    if_addr_in = 32'h80; if_req_in = 1'b1;
    wait_inst_en(20);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mid_rst_inst_en", mem_inst_en_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_inst_addr", mem_inst_addr_out, 0);
    check("mid_rst_inst", if_inst_out, 0);
    check("mid_rst_ld_data", ld_data_out, 0);
    check("mid_rst_data_addr", mem_data_addr_out, 0);
    check("mid_rst_ack", if_ack_out, 0);
    if_req_in = 1'b0;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("mid_rst_no_ack", ack_q.size(), base);
    check("mid_rst_idle", busy_out, 0);

    check("no_ack_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
